uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving the number of clock cycles per bit (100 MHz / 115200 baud); legal range 8..65535.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL have the following ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous reset, active-low.
- RXD  in  1  serial line from the pin; asynchronous to CLK; idles high.
- rx_data  out  8  received byte from the holding register.
- rx_valid  out  1  holding register contains an unconsumed byte.
- rx_ack  in  1  consumer takes the byte; sampled each cycle.
- frame_err  out  1  sticky; a stop bit was sampled low.
- overrun  out  1  sticky; a byte arrived while rx_valid=1 and was dropped.
- busy  out  1  FSM is not in IDLE.

Function
REQ-004 SHALL pass RXD through a 2-flop synchronizer, reset value 1; all logic uses only the synchronized value rxs.
REQ-005 SHALL implement the frame format 8N1: start bit low, 8 data bits LSB first, 1 stop bit high.
REQ-006 SHALL implement FSM states IDLE, START, DATA and STOP; busy=1 in every state except IDLE.
REQ-007 IDLE: SHALL go to START on a falling edge of rxs (previous rxs=1, current rxs=0); a line that is held low SHALL NOT start a frame.
REQ-008 START: SHALL sample rxs after floor(CLKS_PER_BIT/2) cycles.
- rxs=0: go to DATA.
- rxs=1: glitch; go to IDLE; no flag is set.
REQ-009 DATA: SHALL sample one bit every CLKS_PER_BIT cycles into shift register bit index 0..7; a 3-bit counter holds the index; after index 7, go to STOP.
REQ-010 STOP: SHALL sample rxs CLKS_PER_BIT cycles after data bit 7, then return to IDLE in the next cycle.
REQ-011 If the stop sample is 1 and rx_valid=0, or rx_ack=1 in the same cycle: SHALL load the byte into rx_data and set rx_valid=1 on the next edge.
REQ-012 If the stop sample is 1, rx_valid=1 and rx_ack=0: SHALL drop the byte, keep rx_data unchanged and set overrun=1.
REQ-013 If the stop sample is 0: SHALL drop the byte and set frame_err=1; rx_data and rx_valid are unchanged.
REQ-014 The baud counter SHALL be at least 16 bits wide, reload to 0 on every state transition and never wrap within a bit period.
REQ-015 rx_ack with rx_valid=1: SHALL clear rx_valid, frame_err and overrun on the next edge, unless REQ-011 loads a new byte in the same cycle, in which case rx_valid stays 1 and the flags still clear.
REQ-016 rx_ack with rx_valid=0: SHALL be ignored.
REQ-017 rx_data SHALL be stable while rx_valid=1, except when a load occurs under REQ-011.
REQ-018 Latency: rx_valid SHALL rise exactly 1 cycle after the stop-bit sample cycle.
REQ-019 The receiver SHALL accept back-to-back frames with no idle bit between them: the IDLE edge detect arms in the cycle after STOP.

Reset
REQ-020 While RST=0, regardless of clock: SHALL hold state=IDLE, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1 and all counters=0.
REQ-021 RST asserted mid-frame SHALL discard the partial byte; after release the receiver SHALL wait for a fresh falling edge.
REQ-022 The first rising CLK edge after RST deasserts SHALL operate normally with no extra latency.

Verification
(All scenarios use CLKS_PER_BIT=16.)
REQ-023 Frame 0xA5, valid stop bit -> rx_valid rises 1 cycle after the stop sample; rx_data=8'hA5; frame_err=0; overrun=0.
REQ-024 Frames 0x3C then 0xC3 back-to-back, no rx_ack -> rx_data=8'h3C; overrun=1. Then pulse rx_ack -> rx_valid=0; overrun=0.
REQ-025 Frame 0x55 with the stop bit driven low -> frame_err=1; rx_valid=0; rx_data=8'h00. A following valid frame 0x12 -> rx_data=8'h12; frame_err stays 1 until rx_ack.
REQ-026 RXD low pulse of 4 cycles (shorter than CLKS_PER_BIT/2) -> FSM returns to IDLE; no flags set; rx_valid=0.
REQ-027 RST driven low at data bit 4 of frame 0xFF, released, then frame 0x81 sent -> rx_data=8'h81; no spurious byte delivered.
REQ-028 rx_ack asserted in the same cycle as the stop sample of a second frame (0x01 then 0x02) -> rx_valid stays 1; rx_data=8'h02; overrun=0.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with a single-byte holding register, sticky framing/overrun flags
// and a consumer acknowledge handshake.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLast = 16'((CLKS_PER_BIT / 2) - 1);

  logic        rx_meta_q, rxs_q, rxs_prev_q;
  logic [1:0]  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        stop_sample;
  logic        ack_take, load, drop, ferr;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
    case (state_q)
      StIdle: begin
        baud_d = 16'd0;
        // Edge, not level: a line stuck low never starts a frame.
        if (rxs_prev_q && !rxs_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_q == HalfLast) begin
          baud_d    = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = rxs_q ? StIdle : StData;
        end
      end
      StData: begin
        if (baud_q == BitLast) begin
          baud_d             = 16'd0;
          shift_d[bit_idx_q] = rxs_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (baud_q == BitLast) begin
          baud_d      = 16'd0;
          stop_sample = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        baud_d  = 16'd0;
        state_d = StIdle;
      end
    endcase
  end

  // An ack only counts against a byte actually held.
  assign ack_take = rx_ack && rx_valid_q;
  assign load     = stop_sample && rxs_q && (!rx_valid_q || rx_ack);
  assign drop     = stop_sample && rxs_q && rx_valid_q && !rx_ack;
  assign ferr     = stop_sample && !rxs_q;

  always_comb begin
    rx_data_d   = load ? shift_q : rx_data_q;
    rx_valid_d  = load | (rx_valid_q & ~ack_take);
    frame_err_d = ferr | (frame_err_q & ~ack_take);
    overrun_d   = drop | (overrun_q & ~ack_take);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      state_q     <= StIdle;
      baud_q      <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= RXD;
      rxs_q       <= rx_meta_q;
      rxs_prev_q  <= rxs_q;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial frames driven bit by bit, delivered bytes matched
// against a queue of expected bytes, status flags checked after each scenario.
module tb_uart_rx_ctrl;

  localparam int unsigned CPB = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RXD = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int         vectors = 0;
  int         miscompares = 0;
  int         edge_cnt = 0;
  int         last_rise = -1;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RXD      (RXD),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: a byte is delivered when rx_valid rises or the held byte changes.
  always @(posedge CLK) begin
    edge_cnt++;
    #1;
    if (rx_valid === 1'b1 && (!prev_valid || rx_data !== prev_data)) begin
      if (!prev_valid) last_rise = edge_cnt;
      if (exp_q.size() == 0) check("sb_unexpected_byte", 32'(exp_q.size()), 32'd1);
      else check("sb_byte", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    prev_valid = rx_valid;
    prev_data  = rx_data;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called on a negedge; t0 is the posedge count just before the start bit is driven.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_stop,
                            output int t0);
    t0  = edge_cnt;
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RXD = stop;
    for (int k = 0; k < int'(CPB); k++) begin
      // Stop sample lands 2 sync cycles + half a bit into the stop bit.
      if (ack_stop && k == 2 + int'(CPB / 2)) rx_ack = 1'b1;
      if (k == 3 + int'(CPB / 2)) rx_ack = 1'b0;
      @(negedge CLK);
    end
    RXD = 1'b1;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge CLK);
    rx_ack = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    idle(3);
    RST = 1'b1;
    idle(3);
  endtask

  initial begin
    int t0;
    RST = 1'b0;
    RXD = 1'b1;
    #1;
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    idle(2);
    RST = 1'b1;
    idle(2);

    // Single good frame, latency from start edge: 2 sync + 1 detect + half bit + 9 bits.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    idle(4);
    check("a5_latency", 32'(last_rise - t0), 32'(3 + CPB / 2 + 9 * CPB));
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_valid", 32'(rx_valid), 32'd1);
    check("a5_ferr", 32'(frame_err), 32'd0);
    check("a5_ovr", 32'(overrun), 32'd0);
    ack_pulse();
    idle(1);
    check("a5_ack_valid", 32'(rx_valid), 32'd0);
    ack_pulse();
    idle(1);
    check("idle_ack_valid", 32'(rx_valid), 32'd0);
    check("idle_ack_data", 32'(rx_data), 32'hA5);

    // Back-to-back frames with no ack: second byte dropped as overrun.
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, t0);
    send_frame(8'hC3, 1'b1, 1'b0, t0);
    idle(4);
    check("ovr_data", 32'(rx_data), 32'h3C);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    ack_pulse();
    idle(1);
    check("ovr_ack_valid", 32'(rx_valid), 32'd0);
    check("ovr_ack_flag", 32'(overrun), 32'd0);

    // Framing error, then a good byte; error stays sticky until ack.
    do_reset();
    send_frame(8'h55, 1'b0, 1'b0, t0);
    idle(4);
    check("fe_flag", 32'(frame_err), 32'd1);
    check("fe_valid", 32'(rx_valid), 32'd0);
    check("fe_data", 32'(rx_data), 32'h00);
    check("fe_ovr", 32'(overrun), 32'd0);
    idle(10);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0, t0);
    idle(4);
    check("fe_next_data", 32'(rx_data), 32'h12);
    check("fe_next_valid", 32'(rx_valid), 32'd1);
    check("fe_sticky", 32'(frame_err), 32'd1);
    ack_pulse();
    idle(1);
    check("fe_ack_flag", 32'(frame_err), 32'd0);
    check("fe_ack_valid", 32'(rx_valid), 32'd0);

    // Short low glitch: START rejects it.
    do_reset();
    RXD = 1'b0;
    idle(4);
    RXD = 1'b1;
    idle(2);
    check("glitch_busy_mid", 32'(busy), 32'd1);
    idle(20);
    check("glitch_busy_end", 32'(busy), 32'd0);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    check("glitch_ferr", 32'(frame_err), 32'd0);
    check("glitch_ovr", 32'(overrun), 32'd0);

    // Reset in the middle of 0xFF, then a clean 0x81.
    RXD = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      RXD = 1'b1;
      idle(CPB);
    end
    RXD = 1'b1;
    idle(CPB / 2);
    RST = 1'b0;
    idle(1);
    check("midrst_busy", 32'(busy), 32'd0);
    idle(2);
    RST = 1'b1;
    idle(200);
    check("midrst_busy_after", 32'(busy), 32'd0);
    check("midrst_valid", 32'(rx_valid), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, t0);
    idle(4);
    check("midrst_data", 32'(rx_data), 32'h81);
    check("midrst_next_valid", 32'(rx_valid), 32'd1);
    ack_pulse();
    idle(1);

    // Ack coincident with the second frame's stop sample: reload without overrun.
    do_reset();
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b0, t0);
    idle(5);
    exp_q.push_back(8'h02);
    send_frame(8'h02, 1'b1, 1'b1, t0);
    idle(4);
    check("coack_valid", 32'(rx_valid), 32'd1);
    check("coack_data", 32'(rx_data), 32'h02);
    check("coack_ovr", 32'(overrun), 32'd0);
    check("coack_ferr", 32'(frame_err), 32'd0);
    ack_pulse();
    idle(2);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
